// File: rtl/tl_uncached_mem_bridge_if.sv
// rtl/tl_uncached_mem_bridge_if.sv - core request, TileLink acquire/grant and response bundle
// slave is the bridge's view; master is the view of the core plus TileLink side around it.
interface tl_uncached_mem_bridge_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [2:0]  req_typ;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic        acq_valid;
   logic        acq_ready;
   logic [2:0]  acq_type;
   logic [25:0] acq_block;
   logic [2:0]  acq_beat;
   logic [5:0]  acq_xact_id;
   logic [63:0] acq_data;
   logic [7:0]  acq_wmask;
   logic        gnt_valid;
   logic        gnt_ready;
   logic [3:0]  gnt_type;
   logic [5:0]  gnt_xact_id;
   logic [63:0] gnt_data;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport slave (
      input  req_valid, req_wr, req_typ, req_addr, req_wdata,
      output req_ready,
      output acq_valid, acq_type, acq_block, acq_beat, acq_xact_id, acq_data, acq_wmask,
      input  acq_ready,
      input  gnt_valid, gnt_type, gnt_xact_id, gnt_data,
      output gnt_ready,
      output resp_valid, resp_rdata, resp_err
   );

   modport master (
      output req_valid, req_wr, req_typ, req_addr, req_wdata,
      input  req_ready,
      input  acq_valid, acq_type, acq_block, acq_beat, acq_xact_id, acq_data, acq_wmask,
      output acq_ready,
      output gnt_valid, gnt_type, gnt_xact_id, gnt_data,
      input  gnt_ready,
      input  resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/tl_uncached_mem_bridge.sv
// rtl/tl_uncached_mem_bridge.sv - one-at-a-time core load/store to single-beat uncached TileLink bridge
// Misaligned or MT_Q requests bypass the bus and complete with an error.
module tl_uncached_mem_bridge #(
   parameter logic [2:0] ACQ_GET_TYPE = 3'd0,
   parameter logic [2:0] ACQ_PUT_TYPE = 3'd2,
   parameter logic [3:0] GNT_GET_TYPE = 4'd4,
   parameter logic [3:0] GNT_PUT_TYPE = 4'd3
) (
   input logic                      i_clk,
   input logic                      i_nrst,
   tl_uncached_mem_bridge_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACQ, GNT, RESP} state_t;

   state_t      state_q, state_d;
   logic [5:0]  tag_q;
   logic        wr_q;
   logic [2:0]  typ_q;
   logic [2:0]  off_q;
   logic [2:0]  acq_type_q;
   logic [25:0] acq_block_q;
   logic [2:0]  acq_beat_q;
   logic [5:0]  acq_id_q;
   logic [63:0] acq_data_q;
   logic [7:0]  acq_wmask_q;
   logic [63:0] rdata_q;
   logic        err_q;

   logic        req_ready, acq_valid, gnt_ready, resp_valid;
   logic [7:0]  size_mask;
   logic [2:0]  align_mask;
   logic        misaligned;
   logic        gnt_hit;
   logic        gnt_type_ok;
   logic [63:0] shifted;
   logic [63:0] load_ext;

   always_comb begin
      size_mask  = 8'h01;
      align_mask = 3'd0;
      case (bus.req_typ[1:0])
         2'd0: begin size_mask = 8'h01; align_mask = 3'd0; end
         2'd1: begin size_mask = 8'h03; align_mask = 3'd1; end
         2'd2: begin size_mask = 8'h0F; align_mask = 3'd3; end
         default: begin size_mask = 8'hFF; align_mask = 3'd7; end
      endcase
      misaligned = (bus.req_typ == 3'd7) || ((bus.req_addr[2:0] & align_mask) != 3'd0);
   end

   // Grants are matched against the id actually sent, not the already-advanced tag.
   assign gnt_hit     = bus.gnt_valid && (bus.gnt_xact_id == acq_id_q);
   assign gnt_type_ok = bus.gnt_type == (wr_q ? GNT_PUT_TYPE : GNT_GET_TYPE);
   assign shifted     = bus.gnt_data >> {off_q, 3'b000};

   always_comb begin
      load_ext = shifted;
      case (typ_q)
         3'd0:    load_ext = {{56{shifted[7]}},  shifted[7:0]};
         3'd1:    load_ext = {{48{shifted[15]}}, shifted[15:0]};
         3'd2:    load_ext = {{32{shifted[31]}}, shifted[31:0]};
         3'd4:    load_ext = {56'd0, shifted[7:0]};
         3'd5:    load_ext = {48'd0, shifted[15:0]};
         3'd6:    load_ext = {32'd0, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      acq_valid  = 1'b0;
      gnt_ready  = 1'b0;
      resp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = i_nrst;
            if (bus.req_valid && i_nrst) state_d = misaligned ? RESP : ACQ;
         end
         ACQ: begin
            acq_valid = 1'b1;
            if (bus.acq_ready) state_d = GNT;
         end
         GNT: begin
            gnt_ready = 1'b1;
            if (gnt_hit) state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         tag_q       <= 6'd0;
         wr_q        <= 1'b0;
         typ_q       <= 3'd0;
         off_q       <= 3'd0;
         acq_type_q  <= 3'd0;
         acq_block_q <= 26'd0;
         acq_beat_q  <= 3'd0;
         acq_id_q    <= 6'd0;
         acq_data_q  <= 64'd0;
         acq_wmask_q <= 8'd0;
         rdata_q     <= 64'd0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  wr_q        <= bus.req_wr;
                  typ_q       <= bus.req_typ;
                  off_q       <= bus.req_addr[2:0];
                  acq_type_q  <= bus.req_wr ? ACQ_PUT_TYPE : ACQ_GET_TYPE;
                  acq_block_q <= bus.req_addr[31:6];
                  acq_beat_q  <= bus.req_addr[5:3];
                  acq_id_q    <= tag_q;
                  acq_data_q  <= bus.req_wr ? (bus.req_wdata << {bus.req_addr[2:0], 3'b000}) : 64'd0;
                  acq_wmask_q <= bus.req_wr ? (size_mask << bus.req_addr[2:0]) : 8'hFF;
                  rdata_q     <= 64'd0;
                  err_q       <= misaligned;
               end
            end
            ACQ: begin
               if (bus.acq_ready) tag_q <= tag_q + 6'd1;
            end
            GNT: begin
               if (gnt_hit) begin
                  rdata_q <= (wr_q || !gnt_type_ok) ? 64'd0 : load_ext;
                  err_q   <= !gnt_type_ok;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.acq_valid   = acq_valid;
   assign bus.acq_type    = acq_type_q;
   assign bus.acq_block   = acq_block_q;
   assign bus.acq_beat    = acq_beat_q;
   assign bus.acq_xact_id = acq_id_q;
   assign bus.acq_data    = acq_data_q;
   assign bus.acq_wmask   = acq_wmask_q;
   assign bus.gnt_ready   = gnt_ready;
   assign bus.resp_valid  = resp_valid;
   assign bus.resp_rdata  = resp_valid ? rdata_q : 64'd0;
   assign bus.resp_err    = resp_valid & err_q;

endmodule

// File: tb/tb_tl_uncached_mem_bridge.sv
// tb/tb_tl_uncached_mem_bridge.sv - scoreboard bench for tl_uncached_mem_bridge
// Stimulus pushes expected acquires/responses; negedge monitors pop and compare.
module tb_tl_uncached_mem_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tl_uncached_mem_bridge_if bus();

   tl_uncached_mem_bridge dut (
      .i_clk  (clk),
      .i_nrst (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [2:0]  typ;
      logic [25:0] block;
      logic [2:0]  beat;
      logic [5:0]  id;
      logic [63:0] data;
      logic [7:0]  wmask;
   } acq_exp_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          cyc;
   } resp_exp_t;

   acq_exp_t  acq_q[$];
   resp_exp_t resp_q[$];
   acq_exp_t  mon_a;
   resp_exp_t mon_r;
   int        model_tag = 0;
   int        cyc = 0;
   int        n_checks = 0;
   int        n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int size_of(input logic [2:0] typ);
      return 1 << typ[1:0];
   endfunction

   function automatic bit is_misaligned(input logic [2:0] typ, input logic [31:0] addr);
      return (typ == 3'd7) || ((addr % size_of(typ)) != 0);
   endfunction

   // Load result: pick the addressed bytes, then extend by the MT_* signedness.
   function automatic logic [63:0] load_model(input logic [2:0] typ, input logic [2:0] off,
                                              input logic [63:0] d);
      int size;
      logic [63:0] v, m;
      size = size_of(typ);
      v = d >> (8 * off);
      m = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
      v = v & m;
      if (typ < 3 && v[8 * size - 1]) v = v | ~m;
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         check("ctrl_exclusive",
               64'(int'(bus.req_ready) + int'(bus.acq_valid) + int'(bus.gnt_ready) + int'(bus.resp_valid) > 1),
               64'd0);
         if (bus.acq_valid) begin
            if (acq_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL acq_unexpected: got id %0d expected no acquire", bus.acq_xact_id);
            end else begin
               mon_a = acq_q[0];
               check("acq_type",  64'(bus.acq_type),    64'(mon_a.typ));
               check("acq_block", 64'(bus.acq_block),   64'(mon_a.block));
               check("acq_beat",  64'(bus.acq_beat),    64'(mon_a.beat));
               check("acq_id",    64'(bus.acq_xact_id), 64'(mon_a.id));
               check("acq_data",  bus.acq_data,         mon_a.data);
               check("acq_wmask", 64'(bus.acq_wmask),   64'(mon_a.wmask));
               if (bus.acq_ready) void'(acq_q.pop_front());
            end
         end
         if (bus.resp_valid) begin
            if (resp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL resp_unexpected: got rdata 0x%h err %0b expected no response",
                        bus.resp_rdata, bus.resp_err);
            end else begin
               mon_r = resp_q.pop_front();
               check("resp_rdata", bus.resp_rdata, mon_r.rdata);
               check("resp_err",   64'(bus.resp_err), 64'(mon_r.err));
               if (mon_r.cyc >= 0) check("resp_latency", 64'(cyc), 64'(mon_r.cyc));
            end
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.req_ready) return;
      end
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got req_ready 0 expected 1 within 100 cycles");
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"},  64'(bus.req_ready),   64'd0);
      check({tag, "_acq_valid"},  64'(bus.acq_valid),   64'd0);
      check({tag, "_gnt_ready"},  64'(bus.gnt_ready),   64'd0);
      check({tag, "_resp_valid"}, 64'(bus.resp_valid),  64'd0);
      check({tag, "_acq_id"},     64'(bus.acq_xact_id), 64'd0);
      check({tag, "_acq_block"},  64'(bus.acq_block),   64'd0);
      check({tag, "_acq_data"},   bus.acq_data,         64'd0);
      check({tag, "_acq_wmask"},  64'(bus.acq_wmask),   64'd0);
      check({tag, "_resp_rdata"}, bus.resp_rdata,       64'd0);
      check({tag, "_resp_err"},   64'(bus.resp_err),    64'd0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.acq_ready = 1'b0;
      bus.gnt_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      acq_q.delete();
      resp_q.delete();
      model_tag = 0;
      rst_n = 1'b1;
   endtask

   task automatic run_txn(input bit wr, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [63:0] gdata,
                          input logic [3:0] gtype, input int stall, input bit bad_first,
                          input bit rst_in_gnt);
      acq_exp_t  ea;
      resp_exp_t er;
      logic [2:0] off;
      int  c0;
      bit  hs;
      bit  type_ok;
      off = addr[2:0];
      wait_idle();
      bus.req_wr    = wr;
      bus.req_typ   = typ;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_valid = 1'b1;
      bus.acq_ready = (stall == 0);
      @(posedge clk);
      #1;
      c0 = cyc;
      bus.req_valid = 1'b0;
      if (is_misaligned(typ, addr)) begin
         er.rdata = 64'd0;
         er.err   = 1'b1;
         er.cyc   = c0;
         resp_q.push_back(er);
         bus.acq_ready = 1'b0;
         return;
      end
      ea.typ   = wr ? 3'd2 : 3'd0;
      ea.block = 26'(addr / 64);
      ea.beat  = 3'((addr / 8) % 8);
      ea.id    = 6'(model_tag);
      ea.data  = wr ? (wdata << (8 * off)) : 64'd0;
      ea.wmask = wr ? 8'(((1 << size_of(typ)) - 1) << off) : 8'hFF;
      model_tag = (model_tag + 1) % 64;
      acq_q.push_back(ea);
      type_ok  = (gtype == (wr ? 4'd3 : 4'd4));
      er.rdata = (wr || !type_ok) ? 64'd0 : load_model(typ, off, gdata);
      er.err   = !type_ok;
      er.cyc   = (stall == 0 && !bad_first) ? c0 + 2 : -1;
      resp_q.push_back(er);

      hs = 1'b0;
      for (int i = 0; i < 60 && !hs; i++) begin
         @(negedge clk);
         hs = bus.acq_valid && bus.acq_ready;
         @(posedge clk);
         #1;
         if (!hs) bus.acq_ready = (i + 1 >= stall);
      end
      bus.acq_ready = 1'b0;
      if (!hs) begin
         n_checks++; n_fail++;
         $display("FAIL acq_timeout: got no handshake expected one within 60 cycles");
         return;
      end

      if (rst_in_gnt) begin
         rst_n = 1'b0;
         #1;
         check_all_zero("midrst");
         acq_q.delete();
         resp_q.delete();
         model_tag = 0;
         @(negedge clk);
         rst_n = 1'b1;
         bus.gnt_valid   = 1'b1;
         bus.gnt_xact_id = ea.id;
         bus.gnt_type    = gtype;
         bus.gnt_data    = gdata;
         @(negedge clk);
         check("stale_gnt_ready", 64'(bus.gnt_ready), 64'd0);
         check("post_rst_ready",  64'(bus.req_ready), 64'd1);
         @(posedge clk);
         #1;
         bus.gnt_valid = 1'b0;
         return;
      end

      bus.gnt_type = gtype;
      bus.gnt_data = gdata;
      if (bad_first) begin
         bus.gnt_valid   = 1'b1;
         bus.gnt_xact_id = 6'((int'(ea.id) + 5) % 64);
         @(negedge clk);
         check("bad_gnt_ready", 64'(bus.gnt_ready), 64'd1);
         @(posedge clk);
         #1;
      end
      bus.gnt_valid   = 1'b1;
      bus.gnt_xact_id = ea.id;
      @(posedge clk);
      #1;
      bus.gnt_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected completion within 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [63:0] g;
      logic [2:0]  t;
      bit          w;
      logic [3:0]  gt;
      bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_typ = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 64'd0;
      bus.acq_ready = 1'b0;
      bus.gnt_valid = 1'b0; bus.gnt_type = 4'd0; bus.gnt_xact_id = 6'd0; bus.gnt_data = 64'd0;

      apply_reset();
      run_txn(1'b0, 3'd0, 32'h0000_1043, 64'd0, 64'h0000_0000_8000_0000, 4'd4, 0, 1'b0, 1'b0);
      run_txn(1'b1, 3'd1, 32'h0000_2006, 64'h0000_0000_0000_BEEF, 64'h1234_5678_9ABC_DEF0, 4'd3, 0, 1'b0, 1'b0);
      run_txn(1'b0, 3'd2, 32'h0000_1002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 0, 1'b0, 1'b0);
      run_txn(1'b0, 3'd3, 32'h0000_4008, 64'd0, 64'h5555_AAAA_0000_1111, 4'd4, 0, 1'b0, 1'b1);
      run_txn(1'b0, 3'd3, 32'h0000_3010, 64'd0, 64'hCAFE_F00D_1234_5678, 4'd4, 5, 1'b1, 1'b0);

      apply_reset();
      for (int i = 0; i < 65; i++) begin
         a = {$urandom()} & 32'hFFFF_FFFC;
         g = {$urandom(), $urandom()};
         if (a[2]) g[63:32] = 32'hFFFF_FFFF;
         else      g[31:0]  = 32'hFFFF_FFFF;
         run_txn(1'b0, 3'd6, a, 64'd0, g, 4'd4, 0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom_range(0, 1));
         t = 3'($urandom_range(0, 7));
         a = $urandom();
         if ($urandom_range(0, 1) == 0) a[2:0] = a[2:0] & ~3'((size_of(t) - 1));
         g = {$urandom(), $urandom()};
         gt = w ? 4'd3 : 4'd4;
         if ($urandom_range(0, 7) == 0) gt = 4'($urandom_range(5, 15));
         run_txn(w, t, a, {$urandom(), $urandom()}, g, gt,
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      check("acq_queue_drained",  64'(acq_q.size()),  64'd0);
      check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tl_uncached_mem_bridge.md
Name: tl_uncached_mem_bridge

Overview:
Converts single core memory requests (load/store, MT_* size codes) into single-beat uncached TileLink Acquire messages, waits for the matching Grant, and returns a size-extended load result or a store completion to the core. Sits between the core data-port arbiter and the TileLink client port. Uses the shared rocket types: 64-byte blocks, 8 beats of 64 bits, 6-bit transaction IDs. One transaction is outstanding at a time.

Parameters:
ACQ_GET_TYPE, 0, acquire type code for a single-beat get
ACQ_PUT_TYPE, 2, acquire type code for a single-beat put
GNT_GET_TYPE, 4, expected grant type for a get (GRANT_SINGLE_BEAT_GET)
GNT_PUT_TYPE, 3, expected grant type for a put (GRANT_ACK_NON_PREFETCH_PUT)

Ports:
i_clk  in  1  clock, rising edge
i_nrst  in  1  asynchronous active-low reset
i_req_valid  in  1  core request valid
o_req_ready  out  1  bridge idle, can accept a request
i_req_wr  in  1  1 = store, 0 = load
i_req_typ  in  3  MT_B=0 H=1 W=2 D=3 BU=4 HU=5 WU=6 Q=7
i_req_addr  in  32  byte address
i_req_wdata  in  64  store data, right-aligned
o_acq_valid  out  1  acquire valid
i_acq_ready  in  1  acquire accepted
o_acq_type  out  3  ACQ_GET_TYPE / ACQ_PUT_TYPE
o_acq_block  out  26  addr[31:6]
o_acq_beat  out  3  addr[5:3]
o_acq_xact_id  out  6  transaction tag
o_acq_data  out  64  lane-shifted store data
o_acq_wmask  out  8  byte mask
i_gnt_valid  in  1  grant valid
o_gnt_ready  out  1  grant accept
i_gnt_type  in  4  grant type
i_gnt_xact_id  in  6  grant tag
i_gnt_data  in  64  grant beat data
o_resp_valid  out  1  one-cycle completion pulse
o_resp_rdata  out  64  extended load data (0 for stores and errors)
o_resp_err  out  1  misaligned, MT_Q, or grant type mismatch

Behaviour:
- Reset (async, i_nrst=0): state IDLE, tag=0, all outputs 0; o_req_ready goes to 1 only after reset is released. Reset mid-transaction abandons it with no response. A late grant after reset is not consumed (o_gnt_ready=0 in IDLE).
- FSM: IDLE -> ACQ -> GNT -> RESP -> IDLE; ERR path IDLE -> RESP.
- IDLE: o_req_ready=1. On i_req_valid&o_req_ready, latch wr, typ, addr and wdata.
  - Size = 1<<typ[1:0] bytes.
  - Misaligned if addr[2:0] is not a multiple of size, or typ=7. Misaligned requests go directly to RESP with err=1 and issue no acquire.
  - Otherwise go to ACQ.
- ACQ: o_acq_valid=1; all acq fields are registered and held stable until i_acq_ready.
  - Offset = addr[2:0]. wmask = ((1<<size)-1) << offset for puts; 0xFF for gets.
  - data = wdata << (8*offset) for puts; 0 for gets.
  - xact_id = tag. On the handshake, tag increments, wrapping 63->0, and the state moves to GNT.
- GNT: o_gnt_ready=1.
  - A grant whose xact_id differs from the issued tag is consumed and dropped; the state stays GNT.
  - A matching grant latches data and goes to RESP. err=1 if i_gnt_type differs from the expected type for the operation.
- RESP: o_resp_valid=1 for exactly one cycle, then IDLE.
  - Load rdata = (gnt_data >> 8*offset), truncated to size.
  - Sign-extended for typ 0-2; zero-extended for 4-6; typ 3 unmodified.
  - Stores and errors: rdata=0.
- Latency: request accepted at cycle N -> acquire valid at N+1. If i_acq_ready=1 at N+1 and the grant arrives at N+2, the response is at N+3 and ready=1 again at N+4.
- o_req_ready, o_acq_valid, o_gnt_ready and o_resp_valid are mutually exclusive.

Test Plan:
1. Load MT_B at addr 0x0000_1043, grant data 0x0000_0000_8000_0000 -> acq block 0x41, beat 0, id 0, mask 0xFF, type 0; resp rdata 0xFFFF_FFFF_FFFF_FF80, err=0, 3 cycles after acceptance.
2. Store MT_H at 0x2006, wdata 0xBEEF -> acq type 2, data 0xBEEF_0000_0000_0000, mask 0xC0; grant type 3 -> resp rdata 0, err=0.
3. Load MT_W at 0x1002 (misaligned) -> no acq_valid, resp err=1 on the cycle after acceptance; tag unchanged.
4. Hold i_acq_ready=0 for 5 cycles -> acquire fields stable throughout. Then send a grant with id 5 (dropped, no resp) followed by id 0 -> one response.
5. Issue 65 back-to-back loads -> ids 0..63, then 0 (wrap); each MT_WU load of 0xFFFF_FFFF returns 0x0000_0000_FFFF_FFFF.
6. Assert i_nrst=0 while in GNT -> outputs 0 immediately; after release, req_ready=1, next acq id=0, and a stale grant is not accepted.
